// File: rtl/jk_latch_driver_if.sv
// Request/response bundle between register-write logic and jk_latch_driver.
// Valid/ready rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high. The sender holds valid and its payload
// stable until that edge. The receiver may raise or drop ready freely.
interface jk_latch_driver_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             req_tgl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_err;
  logic [WIDTH-1:0] rsp_q;

  modport slave (
    input  req_valid, req_data, req_tgl, rsp_ready,
    output req_ready, rsp_valid, rsp_err, rsp_q
  );

  modport master (
    output req_valid, req_data, req_tgl, rsp_ready,
    input  req_ready, rsp_valid, rsp_err, rsp_q
  );
endinterface

// File: rtl/jk_latch_driver.sv
// Sequences J/K excitation, enable pulse and settle time for a bank of JK latches.
// It reads the bank back and reports whether the readback matches the requested value.
module jk_latch_driver #(
  parameter int WIDTH      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  jk_latch_driver_if.slave bus,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             en,
  input  logic [WIDTH-1:0] q_in,
  output logic             shadow_vld,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [3:0] PLEN_M1 = 4'(PULSE_CYC - 1);
  localparam logic [3:0] SLEN_M1 = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] shadow;
  logic             mode;
  logic             nochg;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [WIDTH-1:0] rsp_q_r;

  logic             accept;
  logic             ex_mode;
  logic             ex_nochg;
  logic [WIDTH-1:0] ex_d;
  logic [WIDTH-1:0] ex_j;
  logic [WIDTH-1:0] ex_k;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_q     = rsp_q_r;
  assign dbg_state     = state;

  // req_ready is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept = bus.req_valid && req_ready_r;

  always_comb begin
    ex_mode  = bus.req_tgl && shadow_vld;
    ex_nochg = shadow_vld && (bus.req_data == shadow);
    ex_d     = bus.req_data ^ shadow;
    ex_j     = '0;
    ex_k     = '0;
    if (!ex_nochg) begin
      if (ex_mode) begin
        ex_j = ex_d;
        ex_k = ex_d;
      end else begin
        ex_j = bus.req_data;
        ex_k = ~bus.req_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: state_nxt = nochg ? CHECK : PULSE;
      // Toggle mode pulses for one cycle only, so a toggled bit cannot race around.
      PULSE: if (mode || cnt == PLEN_M1) state_nxt = (SETTLE_CYC == 0) ? CHECK : HOLD;
      HOLD:  if (cnt == SLEN_M1) state_nxt = CHECK;
      CHECK: state_nxt = RESP;
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Excitation is registered at acceptance so it is already on j/k during SETUP.
  always_comb begin
    j_nxt = '0;
    k_nxt = '0;
    if (accept) begin
      j_nxt = ex_j;
      k_nxt = ex_k;
    end else if (state_nxt == PULSE) begin
      j_nxt = j;
      k_nxt = k;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j           <= '0;
      k           <= '0;
      en          <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_q_r     <= '0;
      shadow_vld  <= 1'b0;
      shadow      <= '0;
      cnt         <= '0;
      tgt         <= '0;
      mode        <= 1'b0;
      nochg       <= 1'b0;
    end else begin
      j           <= j_nxt;
      k           <= k_nxt;
      en          <= (state_nxt == PULSE);
      req_ready_r <= (state_nxt == IDLE);
      rsp_valid_r <= (state_nxt == RESP);
      cnt         <= (state_nxt == state) ? cnt + 4'd1 : 4'd0;
      if (accept) begin
        tgt   <= bus.req_data;
        mode  <= ex_mode;
        nochg <= ex_nochg;
      end
      // The shadow follows real readback, so a mismatch is seen by the next request.
      if (state == CHECK) begin
        rsp_q_r    <= q_in;
        rsp_err_r  <= (q_in != tgt);
        shadow     <= q_in;
        shadow_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_latch_driver.sv
// Directed plus randomized bench for jk_latch_driver with a behavioural JK latch bank.
module tb_jk_latch_driver;
  localparam int WIDTH      = 4;
  localparam int PULSE_CYC  = 2;
  localparam int SETTLE_CYC = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jk_latch_driver_if #(.WIDTH(WIDTH)) bus ();
  logic [WIDTH-1:0] j, k, q_in;
  logic             en, shadow_vld;
  logic [2:0]       dbg_state;

  jk_latch_driver #(
    .WIDTH(WIDTH), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .j(j), .k(k), .en(en), .q_in(q_in),
    .shadow_vld(shadow_vld), .dbg_state(dbg_state)
  );

  // Latch bank: JK applied once per enabled cycle; stuck0 forces bits low.
  logic [WIDTH-1:0] latch_q = '0;
  logic [WIDTH-1:0] stuck0  = '0;

  function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] q, jj, kk);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      case ({jj[i], kk[i]})
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = 1'b0;
        2'b11:   r[i] = ~q[i];
        default: r[i] = q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) if (en) latch_q <= jk_apply(latch_q, j, k) & ~stuck0;
  assign q_in = latch_q & ~stuck0;

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_shadow = '0;
  bit               m_vld    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: one full transaction, entered and left on a negedge
  task automatic do_txn(input logic [WIDTH-1:0] data, input bit tgl, input int bp);
    bit               mode, nochg, seen, jk_bad, rr_bad, stray;
    logic [WIDTH-1:0] ej, ek, eq;
    int               p, elat, n, en_cnt;
    mode  = tgl && m_vld;
    nochg = m_vld && (data == m_shadow);
    if (nochg)     begin ej = '0;              ek = '0;              end
    else if (mode) begin ej = data ^ m_shadow; ek = data ^ m_shadow; end
    else           begin ej = data;            ek = ~data;           end
    p    = nochg ? 0 : (mode ? 1 : PULSE_CYC);
    elat = nochg ? 3 : 3 + p + SETTLE_CYC;
    exp_q.push_back(data & ~stuck0);

    bus.req_valid = 1'b1;
    bus.req_data  = data;
    bus.req_tgl   = tgl;
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_data  = WIDTH'($urandom);
    bus.req_tgl   = 1'($urandom);
    chk("setup_j", j, ej);
    chk("setup_k", k, ek);
    chk("setup_en", en, 0);
    n = 1; en_cnt = 0; jk_bad = 0; rr_bad = 0; seen = 0;
    while (n < 64) begin
      if (bus.rsp_valid) begin seen = 1; break; end
      if (bus.req_ready) rr_bad = 1;
      if (en) begin
        en_cnt++;
        if (j !== ej || k !== ek) jk_bad = 1;
      end else if (n > 1 && (j !== '0 || k !== '0)) jk_bad = 1;
      @(negedge clk);
      n++;
    end
    eq = exp_q.pop_front();
    chk("rsp_seen", seen, 1);
    chk("latency", n, elat);
    chk("en_cycles", en_cnt, p);
    chk("jk_window", jk_bad, 0);
    chk("req_ready_busy", rr_bad, 0);
    chk("rsp_q", bus.rsp_q, eq);
    chk("rsp_err", bus.rsp_err, (eq != data));
    chk("shadow_vld", shadow_vld, 1);

    // backpressure with a stray request that must not be taken
    stray = (bp > 0);
    bus.req_valid = stray;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_q", bus.rsp_q, eq);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_en", en, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
    m_shadow = eq;
    m_vld    = 1'b1;
  endtask

  task automatic reset_in_pulse(input logic [WIDTH-1:0] data);
    int  n;
    bit  rv_bad;
    bus.req_valid = 1'b1;
    bus.req_data  = data;
    bus.req_tgl   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!en && n < 10) begin @(negedge clk); n++; end
    chk("rst_reach_pulse", en, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_shadow_vld", shadow_vld, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    rst = 1'b0;
    rv_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || en) rv_bad = 1;
    end
    chk("rst_no_response", rv_bad, 0);
    m_vld = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_tgl   = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_j", j, 0);
    chk("reset_k", k, 0);
    chk("reset_en", en, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_q", bus.rsp_q, 0);
    chk("reset_shadow_vld", shadow_vld, 0);
    chk("reset_req_ready", bus.req_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    do_txn(4'b1010, 1'b1, 0);   // shadow unknown: set/reset forced
    do_txn(4'b0110, 1'b1, 0);   // toggle: j=k=1100
    do_txn(4'b0110, 1'b1, 5);   // no-change plus backpressure
    stuck0 = 4'b0001;
    do_txn(4'b0001, 1'b0, 0);   // readback mismatch
    do_txn(4'b0011, 1'b1, 1);   // toggle from real readback
    stuck0 = 4'b0000;
    reset_in_pulse(4'b1100);
    do_txn(4'b0101, 1'b1, 0);

    for (int t = 0; t < 24; t++) begin
      d = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      if ($urandom_range(0, 3) == 0) d = m_shadow;
      do_txn(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end
endmodule
